// File: rtl/ro_pair_compare.sv
// Ring-oscillator pair comparator: counts synchronized rising edges of two oscillators
// over a fixed window and reports which ran faster. Define RO_PAIR_COMPARE_DEBUG_EN to expose live counters.
module ro_pair_compare #(
  parameter int WINDOW     = 1000,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ro_a,
  input  logic ro_b,
  output logic ro_en,
  output logic busy,
  output logic resp,
  output logic tie,
  output logic resp_valid,
  input  logic resp_ready
`ifdef RO_PAIR_COMPARE_DEBUG_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  localparam int TMAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]    WINDOW_LD = TW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, HOLD} state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;
  logic [1:0]       a_sync, b_sync;
  logic             a_prev, b_prev;
  logic             rise_a, rise_b;

  // Synchronizers and edge detectors run continuously, independent of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync <= '0;
      b_sync <= '0;
      a_prev <= 1'b0;
      b_prev <= 1'b0;
    end else begin
      a_sync <= {a_sync[0], ro_a};
      b_sync <= {b_sync[0], ro_b};
      a_prev <= a_sync[1];
      b_prev <= b_sync[1];
    end
  end

  assign rise_a = a_sync[1] & ~a_prev;
  assign rise_b = b_sync[1] & ~b_prev;

  always_comb begin
    state_n = state;
    timer_n = timer;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SETTLE;
          timer_n = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (timer == '0) begin
          state_n = MEASURE;
          timer_n = WINDOW_LD;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      MEASURE: begin
        if (timer == '0) state_n = COMPARE;
        else             timer_n = timer - 1'b1;
      end
      COMPARE: state_n = HOLD;
      HOLD:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next-state decode so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      ro_en      <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      ro_en      <= (state_n == SETTLE) || (state_n == MEASURE);
      busy       <= (state_n != IDLE);
      resp_valid <= (state_n == HOLD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if ((state == IDLE) && start) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (state == MEASURE) begin
      if (rise_a && (cnt_a_q != CNT_MAX)) cnt_a_q <= cnt_a_q + 1'b1;
      if (rise_b && (cnt_b_q != CNT_MAX)) cnt_b_q <= cnt_b_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp <= 1'b0;
      tie  <= 1'b0;
    end else if (state == COMPARE) begin
      resp <= (cnt_a_q > cnt_b_q);
      tie  <= (cnt_a_q == cnt_b_q);
    end
  end

`ifdef RO_PAIR_COMPARE_DEBUG_EN
  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_ro_pair_compare.sv
// Scoreboard bench for ro_pair_compare: a fast-window instance and a narrow-counter
// saturation instance, driven by free-running oscillator models.
module tb_ro_pair_compare;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic osc2 = 1'b0, osc4 = 1'b0, osc6 = 1'b0, osc8 = 1'b0;
  initial begin
    #3;
    fork
      forever #10 osc2 = ~osc2;
      forever #20 osc4 = ~osc4;
      forever #30 osc6 = ~osc6;
      forever #40 osc8 = ~osc8;
    join
  end

  logic tie_mode = 1'b0;
  logic start_m = 1'b0, ready_m = 1'b0;
  logic ro_en_m, busy_m, resp_m, tie_m, rv_m;
  logic start_s = 1'b0, ready_s = 1'b0;
  logic ro_en_s, busy_s, resp_s, tie_s, rv_s;
  logic ro_a_m;
  assign ro_a_m = tie_mode ? osc6 : osc4;

  ro_pair_compare #(.WINDOW(24), .SETTLE_CYC(4)) dut_m (
    .clk(clk), .rst(rst), .start(start_m), .ro_a(ro_a_m), .ro_b(osc6),
    .ro_en(ro_en_m), .busy(busy_m), .resp(resp_m), .tie(tie_m),
    .resp_valid(rv_m), .resp_ready(ready_m)
  );

  ro_pair_compare #(.WINDOW(40), .SETTLE_CYC(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .ro_a(osc2), .ro_b(osc8),
    .ro_en(ro_en_s), .busy(busy_s), .resp(resp_s), .tie(tie_s),
    .resp_valid(rv_s), .resp_ready(ready_s)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic resp;
    logic tie;
  } exp_t;
  exp_t q_m[$];
  exp_t q_s[$];
  exp_t e_m, e_s;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic prev_m = 1'b0, prev_s = 1'b0;
  always @(negedge clk) begin
    if (rv_m && !prev_m) begin
      if (q_m.size() == 0) chk("main unexpected resp_valid", 0, 1);
      else begin
        e_m = q_m.pop_front();
        chk("main valid cycle", cyc, e_m.cyc);
        chk("main resp", resp_m, e_m.resp);
        chk("main tie", tie_m, e_m.tie);
      end
    end
    prev_m = rv_m;
  end

  always @(negedge clk) begin
    if (rv_s && !prev_s) begin
      if (q_s.size() == 0) chk("sat unexpected resp_valid", 0, 1);
      else begin
        e_s = q_s.pop_front();
        chk("sat valid cycle", cyc, e_s.cyc);
        chk("sat resp", resp_s, e_s.resp);
        chk("sat tie", tie_s, e_s.tie);
      end
    end
    prev_s = rv_s;
  end

  // Called at a negedge; start is sampled on the following posedge (cycle k).
  task automatic start_main(output int k);
    start_m = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start_m = 1'b0;
  endtask

  task automatic wait_rv_m(input int budget);
    for (int i = 0; i < budget && !rv_m; i++) @(negedge clk);
    chk("main resp_valid timeout", rv_m, 1);
  endtask

  initial begin
    int k;
    #1 rst = 1'b1;
    #1;
    chk("rst ro_en", ro_en_m, 0);
    chk("rst busy", busy_m, 0);
    chk("rst resp", resp_m, 0);
    chk("rst tie", tie_m, 0);
    chk("rst resp_valid", rv_m, 0);
    chk("rst sat busy", busy_s, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // A: period 4 vs 6 -> 6 vs 4 edges, with stray start/ready pulses before HOLD
    start_main(k);
    q_m.push_back('{cyc: k + 29, resp: 1'b1, tie: 1'b0});
    chk("A busy after start", busy_m, 1);
    chk("A ro_en in settle", ro_en_m, 1);
    start_m = 1'b1; ready_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0; ready_m = 1'b0;
    repeat (5) @(negedge clk);
    start_m = 1'b1; ready_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0; ready_m = 1'b0;
    wait_rv_m(60);
    chk("A ro_en in hold", ro_en_m, 0);
    chk("A busy in hold", busy_m, 1);
    repeat (10) begin
      @(negedge clk);
      chk("A hold resp_valid", rv_m, 1);
      chk("A hold resp", resp_m, 1);
      chk("A hold tie", tie_m, 0);
    end
    ready_m = 1'b1; start_m = 1'b1;
    @(negedge clk);
    ready_m = 1'b0; start_m = 1'b0;
    chk("A resp_valid after accept", rv_m, 0);
    chk("A busy after accept", busy_m, 0);
    chk("A resp held in idle", resp_m, 1);
    repeat (3) @(negedge clk);
    chk("A start at handshake ignored", busy_m, 0);

    // B: both oscillators period 6, in phase -> tie
    tie_mode = 1'b1;
    ready_m = 1'b1;
    start_main(k);
    q_m.push_back('{cyc: k + 29, resp: 1'b0, tie: 1'b1});
    wait_rv_m(60);
    @(negedge clk);
    chk("B resp_valid one cycle", rv_m, 0);
    chk("B busy after accept", busy_m, 0);
    repeat (4) @(negedge clk);
    chk("B tie held in idle", tie_m, 1);
    chk("B resp held in idle", resp_m, 0);

    // C: reset in cycle 5 of MEASURE abandons the measurement
    tie_mode = 1'b0;
    ready_m = 1'b0;
    start_main(k);
    repeat (8) @(negedge clk);
    chk("C ro_en in measure", ro_en_m, 1);
    rst = 1'b1;
    #1;
    chk("C rst ro_en", ro_en_m, 0);
    chk("C rst busy", busy_m, 0);
    chk("C rst tie", tie_m, 0);
    chk("C rst resp_valid", rv_m, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("C no resp_valid after abort", rv_m, 0);
    chk("C idle after abort", busy_m, 0);
    ready_m = 1'b1;
    start_main(k);
    q_m.push_back('{cyc: k + 29, resp: 1'b1, tie: 1'b0});
    wait_rv_m(60);
    @(negedge clk);
    ready_m = 1'b0;

    // D: 3-bit counters, 20 edges on A saturate at 7, 5 edges on B
    ready_s = 1'b1;
    start_s = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start_s = 1'b0;
    q_s.push_back('{cyc: k + 45, resp: 1'b1, tie: 1'b0});
    for (int i = 0; i < 100 && !rv_s; i++) @(negedge clk);
    chk("D sat resp_valid timeout", rv_s, 1);
    @(negedge clk);
    chk("D sat busy after accept", busy_s, 0);

    repeat (5) @(negedge clk);
    chk("main scoreboard drained", q_m.size(), 0);
    chk("sat scoreboard drained", q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
